// File: rtl/bit_serial_adder_pkg.sv
// rtl/bit_serial_adder_pkg.sv - shared FSM encoding and default width for the bit-serial adder
package bit_serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/decoder_fa.sv
// rtl/decoder_fa.sv - full-adder cell decoded from its 3-bit input {a, b, carry}
module decoder_fa (
    input  logic [2:0] i_in,
    output logic       o_sum,
    output logic       o_carry
);

    always_comb begin
        o_sum   = 1'b0;
        o_carry = 1'b0;
        case (i_in)
            3'b001, 3'b010, 3'b100: o_sum = 1'b1;
            3'b011, 3'b101, 3'b110: o_carry = 1'b1;
            3'b111: begin
                o_sum   = 1'b1;
                o_carry = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/bit_serial_adder.sv
// rtl/bit_serial_adder.sv - LSB-first bit-serial adder, one operand bit per RUN cycle
module bit_serial_adder
    import bit_serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_sum_sr;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry_q;
    logic             r_cout;
    logic [CNT_W-1:0] r_bit_cnt;
    logic             w_fa_sum;
    logic             w_fa_carry;
    logic             w_last;

    decoder_fa u_fa (
        .i_in    ({r_a_sr[0], r_b_sr[0], r_carry_q}),
        .o_sum   (w_fa_sum),
        .o_carry (w_fa_carry)
    );

    assign w_last = (r_bit_cnt == LAST_BIT);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start) w_next_state = RUN;
            RUN:     if (w_last) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Outputs only move on the final RUN cycle, so they hold the previous result throughout RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sr    <= '0;
            r_b_sr    <= '0;
            r_sum_sr  <= '0;
            r_carry_q <= 1'b0;
            r_bit_cnt <= '0;
            r_sum     <= '0;
            r_cout    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a_sr    <= a;
                        r_b_sr    <= b;
                        r_carry_q <= cin;
                        r_bit_cnt <= '0;
                    end
                end
                RUN: begin
                    r_a_sr    <= {1'b0, r_a_sr[WIDTH-1:1]};
                    r_b_sr    <= {1'b0, r_b_sr[WIDTH-1:1]};
                    r_sum_sr  <= {w_fa_sum, r_sum_sr[WIDTH-1:1]};
                    r_carry_q <= w_fa_carry;
                    if (!w_last) begin
                        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                    end else begin
                        r_sum  <= {w_fa_sum, r_sum_sr[WIDTH-1:1]};
                        r_cout <= w_fa_carry;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_bit_serial_adder.sv
// tb/tb_bit_serial_adder.sv - scoreboard bench for bit_serial_adder at WIDTH=8 and WIDTH=4
module tb_bit_serial_adder;

    localparam int W8 = 8;
    localparam int W4 = 4;

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        int         edge_n;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    logic          start8 = 1'b0, cin8 = 1'b0;
    logic [W8-1:0] a8 = '0, b8 = '0;
    logic          busy8, done8, cout8;
    logic [W8-1:0] sum8;
    logic [W8-1:0] exp8_sum = '0;
    logic          exp8_cout = 1'b0;

    logic          start4 = 1'b0, cin4 = 1'b0;
    logic [W4-1:0] a4 = '0, b4 = '0;
    logic          busy4, done4, cout4;
    logic [W4-1:0] sum4;
    logic [W4-1:0] exp4_sum = '0;
    logic          exp4_cout = 1'b0;

    exp_t q8[$];
    exp_t q4[$];
    int   cyc = 0;
    int   nxt8 = 0, nxt4 = 0;
    int   checks = 0, errors = 0;

    bit_serial_adder #(.WIDTH(W8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    bit_serial_adder #(.WIDTH(W4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    always #5 clk = ~clk;

    // Acceptance model: start is taken only once the previous op has had WIDTH+2 edges.
    always @(posedge clk) begin
        if (!rst_n) begin
            q8.delete();
            q4.delete();
            nxt8 <= 0;
            nxt4 <= 0;
        end else begin
            if (start8 && cyc >= nxt8) begin
                q8.push_back('{exp8_sum, exp8_cout, cyc + W8});
                nxt8 <= cyc + W8 + 2;
            end
            if (start4 && cyc >= nxt4) begin
                q4.push_back('{{4'b0, exp4_sum}, exp4_cout, cyc + W4});
                nxt4 <= cyc + W4 + 2;
            end
        end
        cyc <= cyc + 1;
    end

    logic          pd8 = 1'b0, pb8 = 1'b0, pd4 = 1'b0, pb4 = 1'b0;
    logic [W8-1:0] ps8 = '0;
    logic [W4-1:0] ps4 = '0;

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (done8) begin
                checks++;
                if (q8.size() == 0) begin
                    errors++;
                    $display("FAIL done8_unexpected: done at edge %0d with no pending op", cyc - 1);
                end else begin
                    e = q8.pop_front();
                    if ({sum8, cout8} != {e.sum, e.cout}) begin
                        errors++;
                        $display("FAIL result8: got sum=%h cout=%b, expected sum=%h cout=%b", sum8, cout8, e.sum, e.cout);
                    end
                    checks++;
                    if (cyc - 1 != e.edge_n) begin
                        errors++;
                        $display("FAIL latency8: done after edge %0d, expected %0d", cyc - 1, e.edge_n);
                    end
                end
            end
            if (done4) begin
                checks++;
                if (q4.size() == 0) begin
                    errors++;
                    $display("FAIL done4_unexpected: done at edge %0d with no pending op", cyc - 1);
                end else begin
                    e = q4.pop_front();
                    if ({sum4, cout4} != {e.sum[3:0], e.cout}) begin
                        errors++;
                        $display("FAIL result4: got sum=%h cout=%b, expected sum=%h cout=%b", sum4, cout4, e.sum[3:0], e.cout);
                    end
                    checks++;
                    if (cyc - 1 != e.edge_n) begin
                        errors++;
                        $display("FAIL latency4: done after edge %0d, expected %0d", cyc - 1, e.edge_n);
                    end
                end
            end
            checks++;
            if ((busy8 && done8) || (busy4 && done4)) begin
                errors++;
                $display("FAIL busy_and_done: busy8=%b done8=%b busy4=%b done4=%b, expected never both", busy8, done8, busy4, done4);
            end
            checks++;
            if ((done8 && pd8) || (done4 && pd4)) begin
                errors++;
                $display("FAIL done_width: done high two cycles (8:%b 4:%b), expected one", done8 && pd8, done4 && pd4);
            end
            checks++;
            if ((busy8 && pb8 && sum8 != ps8) || (busy4 && pb4 && sum4 != ps4)) begin
                errors++;
                $display("FAIL sum_stable: sum8 %h->%h sum4 %h->%h, expected stable while busy", ps8, sum8, ps4, sum4);
            end
        end
        pd8 = done8; pb8 = busy8; ps8 = sum8;
        pd4 = done4; pb4 = busy4; ps4 = sum4;
    end

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((q8.size() != 0 || q4.size() != 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (q8.size() != 0 || q4.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: pending q8=%0d q4=%0d, expected 0", q8.size(), q4.size());
        end
        @(negedge clk);
    endtask

    task automatic issue8(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                          input logic [7:0] es, input logic ec);
        @(negedge clk);
        a8 = va; b8 = vb; cin8 = vc; exp8_sum = es; exp8_cout = ec;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'hC3; b8 = 8'h99; cin8 = 1'b1;
    endtask

    logic [7:0] ca [3] = '{8'h12, 8'h80, 8'hC8};
    logic [7:0] cb [3] = '{8'h34, 8'h80, 8'h64};
    logic       cc [3] = '{1'b1, 1'b0, 1'b0};
    logic [7:0] cs [3] = '{8'h47, 8'h00, 8'h2C};
    logic       co [3] = '{1'b0, 1'b1, 1'b1};

    initial begin
        logic [4:0] ref4;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_busy8", 16'(busy8), 16'h0);
        chk("reset_done8", 16'(done8), 16'h0);
        chk("reset_sum8", 16'(sum8), 16'h0);
        chk("reset_cout8", 16'(cout8), 16'h0);
        chk("reset_busy4", 16'(busy4), 16'h0);
        chk("reset_sum4", 16'({cout4, sum4}), 16'h0);
        rst_n = 1'b1;

        issue8(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
        drain();
        issue8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        repeat (2) @(negedge clk);
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        drain();
        issue8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
        drain();

        @(negedge clk);
        start8 = 1'b1;
        for (int k = 0; k < 30; k++) begin
            if (k % 10 == 0) begin
                a8 = ca[k / 10]; b8 = cb[k / 10]; cin8 = cc[k / 10];
                exp8_sum = cs[k / 10]; exp8_cout = co[k / 10];
            end else begin
                a8 = 8'(k * 37); b8 = 8'(k * 11 + 5); cin8 = k[0];
                exp8_sum = 8'hEE; exp8_cout = 1'b0;
            end
            @(negedge clk);
        end
        start8 = 1'b0;
        drain();

        @(negedge clk);
        a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b0; exp8_sum = 8'h96; exp8_cout = 1'b0;
        start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        repeat (4) @(posedge clk);
        #1 chk("busy_before_reset", 16'(busy8), 16'h1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 16'(busy8), 16'h0);
        chk("abort_done", 16'(done8), 16'h0);
        chk("abort_sum", 16'(sum8), 16'h0);
        chk("abort_cout", 16'(cout8), 16'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b1; exp8_sum = 8'h81; exp8_cout = 1'b0;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        drain();
        repeat (12) @(negedge clk);

        for (int i = 0; i < 512; i++) begin
            a4 = i[3:0]; b4 = i[7:4]; cin4 = i[8];
            ref4 = 5'(a4) + 5'(b4) + 5'(cin4);
            exp4_sum = ref4[3:0]; exp4_cout = ref4[4];
            start4 = 1'b1;
            @(negedge clk);
            start4 = 1'b0;
            a4 = ~a4; b4 = ~b4;
            repeat (W4 + 1) @(negedge clk);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bit_serial_adder.md
BIT_SERIAL_ADDER -- requirements
Module: bit_serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, meaning operand and result width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 start  input  1  request to add; sampled only in IDLE.
REQ-005 a  input  WIDTH  operand A; captured on an accepted start.
REQ-006 b  input  WIDTH  operand B; captured on an accepted start.
REQ-007 cin  input  1  carry-in; captured on an accepted start.
REQ-008 busy  output  1  high while an addition is in progress (RUN state).
REQ-009 done  output  1  single-cycle pulse; result valid.
REQ-010 sum  output  WIDTH  result of a+b+cin, modulo 2^WIDTH.
REQ-011 cout  output  1  carry out of bit WIDTH-1.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-013 IDLE with start=1 SHALL load a_sr<=a, b_sr<=b, carry_q<=cin, bit_cnt<=0, and go to RUN; start=0 stays in IDLE.
REQ-014 Each RUN cycle SHALL drive the full-adder cell with {a_sr[0], b_sr[0], carry_q} (MSB to LSB of its 3-bit input).
REQ-015 Each RUN cycle SHALL shift a_sr and b_sr right by one, shift the cell sum into the MSB of sum_sr (right shift), load carry_q with the cell carry, and increment bit_cnt.
REQ-016 RUN with bit_cnt==WIDTH-1 SHALL go to DONE; bit_cnt width is clog2(WIDTH), no wrap inside an operation.
REQ-017 On the RUN->DONE edge, sum SHALL load sum_sr with the final bit included and cout SHALL load the final carry.
REQ-018 DONE SHALL assert done for exactly one cycle, then go to IDLE unconditionally.
REQ-019 Latency: start accepted at edge N -> done high in the cycle after edge N+WIDTH (WIDTH+1 cycles start-to-done).
REQ-020 busy SHALL be high exactly in RUN; done and busy SHALL never be high together.
REQ-021 start while in RUN or DONE SHALL be ignored, with no effect on the in-flight operation; a, b and cin changes after acceptance SHALL have no effect.
REQ-022 sum and cout SHALL hold the last completed result until the next completion; they SHALL NOT change during RUN.
REQ-023 Maximum throughput: one result per WIDTH+2 cycles (start re-accepted in the IDLE cycle after DONE).

Reset
REQ-024 rst_n low SHALL immediately force state=IDLE, busy=0, done=0, sum=0, cout=0, and clear a_sr, b_sr, sum_sr, carry_q and bit_cnt.
REQ-025 Reset asserted mid-RUN SHALL abort the operation: no done pulse, and outputs at zero.
REQ-026 On the first rising edge after rst_n deasserts, start=1 SHALL be accepted normally.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default WIDTH constant.
REQ-028 The per-bit adder SHALL be one instance of the team's existing decoder_fa cell (3-bit in; sum and carry out); no other sub-modules.
REQ-029 Datapath and FSM SHALL reside in bit_serial_adder; there SHALL be no combinational path from start, a, b or cin to any output.

Verification
REQ-030 WIDTH=8, a=8'h5A, b=8'h3C, cin=0, start at edge 0 -> done high after edge 8, sum=8'h96, cout=0.
REQ-031 a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1; then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
REQ-032 start held high continuously with new a/b each cycle -> results match only the operands at each acceptance edge; done period = 10 cycles.
REQ-033 rst_n pulsed low at edge 4 of an operation -> busy, done, sum and cout at 0 immediately; no done pulse follows.
REQ-034 Exhaustive WIDTH=4 sweep of all a, b and cin -> every sum/cout equals the reference a+b+cin, and done arrives after edge 4.
REQ-035 Assertion checks throughout: done is one cycle wide; busy&&done is never 1; sum is stable while busy.
